// File: rtl/simd_alu_pipe.sv
// SIMD ALU stage that splits WIDTH bits into 1, 2 or 4 lanes.
// It has an optional input register, a P register with accumulate feedback and registered pattern detect.
module simd_alu_pipe #(
  parameter int WIDTH = 48,
  parameter int LANES = 1,
  parameter int INREG = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cein,
  input  logic               cep,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [WIDTH-1:0]   z,
  input  logic               cin,
  input  logic [3:0]         alumode,
  input  logic               opmode3,
  input  logic               zsel_p,
  input  logic [WIDTH-1:0]   pattern,
  input  logic [WIDTH-1:0]   mask,
  output logic [WIDTH-1:0]   p,
  output logic [LANES-1:0]   carryout,
  output logic               patterndetect,
  output logic               patterndetect_past,
  output logic               overflow
);
  localparam int LW = WIDTH / LANES;

  logic [WIDTH-1:0] x_s, y_s, z_s, z_eff;
  logic             cin_s, opmode3_s, zsel_p_s;
  logic [3:0]       alumode_s;

  logic [WIDTH-1:0] p_q, p_d;
  logic [LANES-1:0] carryout_q, carryout_d;
  logic             pd_q, pd_d, pdp_q, pdp_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] arith_res, alu_res;
  logic [LANES-1:0] arith_co, alu_co;
  logic             pd_next;

  generate
    if (INREG != 0) begin : g_inreg
      logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
      logic             cin_q, cin_d, opmode3_q, opmode3_d, zsel_p_q, zsel_p_d;
      logic [3:0]       alumode_q, alumode_d;

      always_comb begin
        x_d = x_q; y_d = y_q; z_d = z_q; cin_d = cin_q;
        alumode_d = alumode_q; opmode3_d = opmode3_q; zsel_p_d = zsel_p_q;
        if (cein) begin
          x_d = x; y_d = y; z_d = z; cin_d = cin;
          alumode_d = alumode; opmode3_d = opmode3; zsel_p_d = zsel_p;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          x_q <= '0; y_q <= '0; z_q <= '0; cin_q <= 1'b0;
          alumode_q <= 4'b0000; opmode3_q <= 1'b0; zsel_p_q <= 1'b0;
        end else begin
          x_q <= x_d; y_q <= y_d; z_q <= z_d; cin_q <= cin_d;
          alumode_q <= alumode_d; opmode3_q <= opmode3_d; zsel_p_q <= zsel_p_d;
        end
      end

      assign x_s = x_q; assign y_s = y_q; assign z_s = z_q; assign cin_s = cin_q;
      assign alumode_s = alumode_q; assign opmode3_s = opmode3_q; assign zsel_p_s = zsel_p_q;
    end else begin : g_noreg
      logic unused_cein;
      assign unused_cein = cein;
      assign x_s = x; assign y_s = y; assign z_s = z; assign cin_s = cin;
      assign alumode_s = alumode; assign opmode3_s = opmode3; assign zsel_p_s = zsel_p;
    end
  endgenerate

  // Feedback taps the live P register, so a held input stage still accumulates.
  assign z_eff = zsel_p_s ? p_q : z_s;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LW:0] xe, ye, ze, zn, ce, lane_res;
      assign xe = {1'b0, x_s[gi*LW +: LW]};
      assign ye = {1'b0, y_s[gi*LW +: LW]};
      assign ze = {1'b0, z_eff[gi*LW +: LW]};
      assign zn = {1'b0, ~z_eff[gi*LW +: LW]};
      assign ce = (gi == 0) ? {{LW{1'b0}}, cin_s} : '0;

      always_comb begin
        lane_res = '0;
        case (alumode_s)
          4'b0000: lane_res = xe + ye + ze + ce;
          4'b0001: lane_res = xe + ye + zn + ce;
          4'b0010: lane_res = ~(xe + ye + ze + ce);
          4'b0011: lane_res = ze - xe - ye - ce;
          default: lane_res = '0;
        endcase
      end

      assign arith_res[gi*LW +: LW] = lane_res[LW-1:0];
      assign arith_co[gi]           = lane_res[LW];
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    alu_co  = '0;
    case (alumode_s)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        alu_res = arith_res;
        alu_co  = arith_co;
      end
      4'b0100, 4'b0111: alu_res = opmode3_s ? ~(x_s ^ z_eff) : (x_s ^ z_eff);
      4'b0101, 4'b0110: alu_res = opmode3_s ? (x_s ^ z_eff) : ~(x_s ^ z_eff);
      4'b1100: alu_res = opmode3_s ? (x_s | z_eff) : (x_s & z_eff);
      4'b1101: alu_res = opmode3_s ? (x_s | ~z_eff) : (x_s & ~z_eff);
      4'b1110: alu_res = opmode3_s ? ~(x_s | z_eff) : ~(x_s & z_eff);
      4'b1111: alu_res = opmode3_s ? (~x_s & z_eff) : (~x_s | z_eff);
      default: alu_res = '0;
    endcase
  end

  assign pd_next = &(~(alu_res ^ pattern) | mask);

  always_comb begin
    p_d = p_q; carryout_d = carryout_q;
    pd_d = pd_q; pdp_d = pdp_q; ovf_d = ovf_q;
    if (cep) begin
      p_d        = alu_res;
      carryout_d = alu_co;
      pd_d       = pd_next;
      pdp_d      = pd_q;
      ovf_d      = pd_q & ~pd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0; carryout_q <= '0;
      pd_q <= 1'b0; pdp_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      p_q <= p_d; carryout_q <= carryout_d;
      pd_q <= pd_d; pdp_q <= pdp_d; ovf_q <= ovf_d;
    end
  end

  assign p                  = p_q;
  assign carryout           = carryout_q;
  assign patterndetect      = pd_q;
  assign patterndetect_past = pdp_q;
  assign overflow           = ovf_q;
endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe across four configurations sharing one stimulus bus.
// Expectations are queued with the cycle they are due; a negedge monitor pops and compares.
module tb_simd_alu_pipe;
  logic        clk = 1'b0;
  logic        rst, cein, cep, cin, opmode3, zsel_p;
  logic [47:0] x, y, z, pattern, mask;
  logic [3:0]  alumode;

  logic [47:0] p_a, p_b, p_c, p_d;
  logic [0:0]  co_a, co_d;
  logic [3:0]  co_b;
  logic [1:0]  co_c;
  logic        pd_a, pdp_a, ovf_a, pd_b, pdp_b, ovf_b;
  logic        pd_c, pdp_c, ovf_c, pd_d, pdp_d, ovf_d;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int          due;
    int          dut;
    logic [47:0] p;
    logic [3:0]  co;
    bit          chk_pd;
    logic [2:0]  pdv;
    string       name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simd_alu_pipe #(.WIDTH(48), .LANES(1), .INREG(0)) u_a (
    .clk(clk), .rst(rst), .cein(cein), .cep(cep), .x(x), .y(y), .z(z), .cin(cin),
    .alumode(alumode), .opmode3(opmode3), .zsel_p(zsel_p), .pattern(pattern), .mask(mask),
    .p(p_a), .carryout(co_a), .patterndetect(pd_a), .patterndetect_past(pdp_a), .overflow(ovf_a));
  simd_alu_pipe #(.WIDTH(48), .LANES(4), .INREG(0)) u_b (
    .clk(clk), .rst(rst), .cein(cein), .cep(cep), .x(x), .y(y), .z(z), .cin(cin),
    .alumode(alumode), .opmode3(opmode3), .zsel_p(zsel_p), .pattern(pattern), .mask(mask),
    .p(p_b), .carryout(co_b), .patterndetect(pd_b), .patterndetect_past(pdp_b), .overflow(ovf_b));
  simd_alu_pipe #(.WIDTH(48), .LANES(2), .INREG(0)) u_c (
    .clk(clk), .rst(rst), .cein(cein), .cep(cep), .x(x), .y(y), .z(z), .cin(cin),
    .alumode(alumode), .opmode3(opmode3), .zsel_p(zsel_p), .pattern(pattern), .mask(mask),
    .p(p_c), .carryout(co_c), .patterndetect(pd_c), .patterndetect_past(pdp_c), .overflow(ovf_c));
  simd_alu_pipe #(.WIDTH(48), .LANES(1), .INREG(1)) u_d (
    .clk(clk), .rst(rst), .cein(cein), .cep(cep), .x(x), .y(y), .z(z), .cin(cin),
    .alumode(alumode), .opmode3(opmode3), .zsel_p(zsel_p), .pattern(pattern), .mask(mask),
    .p(p_d), .carryout(co_d), .patterndetect(pd_d), .patterndetect_past(pdp_d), .overflow(ovf_d));

  // Expectation for the state after the next rising edge.
  task automatic push(input int dut, input logic [47:0] ep, input logic [3:0] eco,
                      input bit chk, input logic [2:0] pdv, input string name);
    exp_t e;
    e.due = cyc + 1; e.dut = dut; e.p = ep; e.co = eco;
    e.chk_pd = chk; e.pdv = pdv; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  exp_t        it;
  logic [47:0] ap;
  logic [3:0]  aco;
  logic [2:0]  apd;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      case (it.dut)
        0: begin ap = p_a; aco = {3'b000, co_a}; apd = {pd_a, pdp_a, ovf_a}; end
        1: begin ap = p_b; aco = co_b;           apd = {pd_b, pdp_b, ovf_b}; end
        2: begin ap = p_c; aco = {2'b00, co_c};  apd = {pd_c, pdp_c, ovf_c}; end
        default: begin ap = p_d; aco = {3'b000, co_d}; apd = {pd_d, pdp_d, ovf_d}; end
      endcase
      if (it.due < cyc) begin
        total++; bad++;
        $display("FAIL %s: check slot cycle %0d passed (now %0d)", it.name, it.due, cyc);
      end else begin
        total++;
        if (ap !== it.p) begin
          bad++;
          $display("FAIL %s p: got %h want %h", it.name, ap, it.p);
        end
        total++;
        if (aco !== it.co) begin
          bad++;
          $display("FAIL %s carryout: got %b want %b", it.name, aco, it.co);
        end
        if (it.chk_pd) begin
          total++;
          if (apd !== it.pdv) begin
            bad++;
            $display("FAIL %s pd/past/ovf: got %b want %b", it.name, apd, it.pdv);
          end
        end
        $display("cyc %0d %s: p=%h co=%b pd/past/ovf=%b", cyc, it.name, ap, aco, apd);
      end
    end
  end

  logic prev_pd, cur_pd;
  logic [47:0] acc_exp;

  initial begin
    rst = 1'b1; cein = 1'b1; cep = 1'b1; cin = 1'b1; opmode3 = 1'b0; zsel_p = 1'b0;
    x = 48'hAAAA_AAAA_AAAA; y = 48'h5555_5555_5555; z = 48'h123; alumode = 4'b0000;
    pattern = 48'd0; mask = 48'd0;

    // Reset dominates even with cep=1 and nonzero operands.
    for (int i = 0; i < 2; i++) begin
      push(0, 48'd0, 4'b0000, 1'b1, 3'b000, "reset");
      step();
    end
    rst = 1'b0; x = 48'd3; y = 48'd4; z = 48'd5; cin = 1'b1;
    push(0, 48'd13, 4'b0000, 1'b1, 3'b000, "first_after_rst");
    step();

    // Four 12-bit lanes: carries must not cross lanes.
    x = 48'hFFF_FFF_FFF_FFF; y = 48'h001_001_001_001; z = 48'd0; cin = 1'b0;
    push(1, 48'd0, 4'b1111, 1'b0, 3'b000, "lane4_add");
    step();
    cin = 1'b1;
    push(1, 48'h000_000_000_001, 4'b1111, 1'b0, 3'b000, "lane4_add_cin");
    step();
    alumode = 4'b0001; x = 48'h002_002_002_002; y = 48'd0; z = 48'd0; cin = 1'b0;
    push(1, 48'h001_001_001_001, 4'b1111, 1'b0, 3'b000, "lane4_add_notz");
    step();

    // Two 24-bit lanes: subtract and complemented sum.
    alumode = 4'b0011; x = 48'h000007_000007; y = 48'd0; z = 48'h000005_000005;
    push(2, 48'hFFFFFE_FFFFFE, 4'b0011, 1'b0, 3'b000, "lane2_sub");
    step();
    cin = 1'b1;
    push(2, 48'hFFFFFE_FFFFFD, 4'b0011, 1'b0, 3'b000, "lane2_sub_cin");
    step();
    alumode = 4'b0010; cin = 1'b0;
    x = 48'h000001_000001; y = 48'h000002_000002; z = 48'h000003_000003;
    push(2, 48'hFFFFF9_FFFFF9, 4'b0011, 1'b0, 3'b000, "lane2_notsum");
    step();

    // Logic ops and the undefined-code default on the 48-bit instance.
    alumode = 4'b0000; x = 48'hFFFF_FFFF_FFFF; y = 48'd1; z = 48'd0;
    push(0, 48'd0, 4'b0001, 1'b0, 3'b000, "wide_carry");
    step();
    alumode = 4'b1101; opmode3 = 1'b1; x = 48'h0F0; y = 48'd0; z = 48'h0FF;
    push(0, 48'hFFFF_FFFF_FFF0, 4'b0000, 1'b0, 3'b000, "or_notz");
    step();
    alumode = 4'b1000;
    push(0, 48'd0, 4'b0000, 1'b0, 3'b000, "undefined_op");
    step();
    alumode = 4'b1100; opmode3 = 1'b0;
    push(0, 48'h0F0, 4'b0000, 1'b0, 3'b000, "and");
    step();
    alumode = 4'b0100;
    push(0, 48'h00F, 4'b0000, 1'b0, 3'b000, "xor");
    step();
    alumode = 4'b1110; opmode3 = 1'b1;
    push(0, 48'hFFFF_FFFF_FF00, 4'b0000, 1'b0, 3'b000, "nor");
    step();

    // Accumulate +1 through the INREG=1 instance with pattern detect at 4.
    rst = 1'b1; alumode = 4'b0000; opmode3 = 1'b0; x = 48'd1; y = 48'd0; z = 48'd0;
    cin = 1'b0; zsel_p = 1'b1; pattern = 48'd4; mask = 48'd0;
    push(3, 48'd0, 4'b0000, 1'b1, 3'b000, "acc_rst");
    step();
    rst = 1'b0;
    prev_pd = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      acc_exp = 48'(j - 1);
      cur_pd  = (j == 5);
      push(3, acc_exp, 4'b0000, 1'b1, {cur_pd, prev_pd, prev_pd & ~cur_pd}, "acc");
      prev_pd = cur_pd;
      step();
    end
    cep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(3, 48'd10, 4'b0000, 1'b1, 3'b000, "acc_hold");
      step();
    end
    cep = 1'b1;
    push(3, 48'd11, 4'b0000, 1'b0, 3'b000, "acc_resume");
    step();
    rst = 1'b1;
    push(3, 48'd0, 4'b0000, 1'b1, 3'b000, "acc_mid_rst");
    step();
    rst = 1'b0;
    push(3, 48'd0, 4'b0000, 1'b0, 3'b000, "acc_refill");
    step();
    push(3, 48'd1, 4'b0000, 1'b0, 3'b000, "acc_restart");
    step();
    // Held input register keeps adding the captured x=1 to live P.
    cein = 1'b0; x = 48'd5;
    push(3, 48'd2, 4'b0000, 1'b0, 3'b000, "cein_hold");
    step();
    push(3, 48'd3, 4'b0000, 1'b0, 3'b000, "cein_hold");
    step();
    cein = 1'b1;

    for (int i = 0; i < 5 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/simd_alu_pipe.md
Name: simd_alu_pipe

Overview:
- Registered, parametrised successor to the slice ALU stage.
- Splits a WIDTH-bit datapath into 1, 2 or 4 independent SIMD lanes, each with its own carry-out.
- Optional input register stage; mandatory P output register with clock enable; accumulator feedback (z := P); registered pattern detect with a one-cycle history.
- Sits between the X/Y/Z multiplexers and the slice P output.

Parameters:
- WIDTH, 48: total datapath width; must be divisible by LANES.
- LANES, 1: SIMD lane count; legal values 1 (ONE48), 2 (TWO24), 4 (FOUR12). Lane width LW = WIDTH/LANES.
- INREG, 0: 1 inserts an input register on x, y, z, cin, alumode, opmode3, zsel_p; 0 bypasses it.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- cein, input, 1: enable for the input register (ignored when INREG=0).
- cep, input, 1: enable for the P, carryout and pattern registers.
- x, y, z, input, WIDTH each: operands.
- cin, input, 1: carry-in, applied to lane 0 only.
- alumode, input, 4: operation select.
- opmode3, input, 1: logic-op variant select.
- zsel_p, input, 1: 1 replaces z with the current P register value (accumulate).
- pattern, input, WIDTH: compare value.
- mask, input, WIDTH: 1 = bit ignored in compare.
- p, output, WIDTH: registered result.
- carryout, output, LANES: registered per-lane carry, bit i = lane i.
- patterndetect, output, 1: registered match of the result.
- patterndetect_past, output, 1: patterndetect from the previous enabled cycle.
- overflow, output, 1: patterndetect_past & ~patterndetect, registered.

Behaviour:
- Reset is synchronous, active-high, and has priority over cein/cep. It clears the input registers, p, carryout, patterndetect, patterndetect_past and overflow to 0. Reset mid-accumulation discards P; the next feedback uses 0.
- Latency: INREG=0: operands sampled at edge k appear on p after edge k (1 cycle). INREG=1: 2 cycles.
- Feedback path: z_eff = zsel_p ? p_reg : z_stage. Feedback always taps the live P register, never the input register.
- Lane i covers bits [i*LW +: LW]. Arithmetic is computed per lane on LW+1 bits with no carry crossing lanes. Lane cin is cin for lane 0, 0 otherwise.
- Arithmetic ops, with {co,r} the (LW+1)-bit result of each lane:
  - 0000: {co,r} = x + y + z + cin.
  - 0001: {co,r} = x + y + ~z + cin.
  - 0010: {co,r} = ~(x + y + z + cin), complemented over LW+1 bits.
  - 0011: {co,r} = z - x - y - cin, modulo 2^(LW+1).
- Logic ops (lane-independent, all carryout bits = 0):
  - 0100/0111: opmode3 ? ~(x^z) : x^z.
  - 0101/0110: opmode3 ? x^z : ~(x^z).
  - 1100: opmode3 ? x|z : x&z.
  - 1101: opmode3 ? x|~z : x&~z.
  - 1110: opmode3 ? ~(x|z) : ~(x&z).
  - 1111: opmode3 ? ~x&z : ~x|z.
- Any other alumode: result 0, carryout 0.
- pd_next = &(~(result ^ pattern) | mask), where result is the next P value. This is full WIDTH regardless of LANES.
- On an enabled edge (cep=1, rst=0): p <= result; carryout <= lane carries; patterndetect <= pd_next; patterndetect_past <= patterndetect; overflow <= patterndetect & ~pd_next.
- cep=0: all output registers hold. An accumulation with zsel_p=1 and cep=0 does not advance.
- cein=0 with INREG=1: input register holds; the ALU keeps recomputing from held operands plus the live P.
- mask all ones: patterndetect = 1 after the first enabled edge.
- The pipeline has no valid/handshake; outputs are valid every enabled cycle.

Test Plan:
- Reset: LANES=1, drive rst=1 with cep=1 and nonzero operands for 2 cycles -> p=0, carryout=0, patterndetect=0; release rst -> first result appears 1 cycle later.
- Lane isolation: LANES=4, WIDTH=48, alumode=0000, x=48'hFFF_FFF_FFF_FFF, y=48'h001_001_001_001, z=0, cin=0 -> p=0, carryout=4'b1111. Repeat with cin=1 -> lane0=12'h001, others 0.
- Subtract: LANES=2, alumode=0011, z=24'd5 per lane, x=24'd7, y=0, cin=0 -> each lane = 24'hFFFFFE, carryout=2'b11.
- Accumulate: LANES=1, INREG=1, alumode=0000, x=1, y=0, zsel_p=1, cep=1 for 10 cycles from reset -> p counts 1..10 with 2-cycle fill; drop cep for 3 cycles -> p holds; rst mid-run -> p=0 next edge.
- Pattern/overflow: pattern=48'd4, mask=0, accumulate +1 -> patterndetect=1 exactly in the cycle p=4; patterndetect_past=1 in the cycle p=5; overflow=1 in the cycle p=5.
- Logic/default: alumode=1101, opmode3=1, x=48'h0F0, z=48'h0FF -> p=48'hFFFF_FFFF_FFF0, carryout=0; alumode=1000 -> p=0, carryout=0.
